// File: rtl/reduce_pkt_tx_if.sv
// rtl/reduce_pkt_tx_if.sv - payload-in / packet-out handshake bundle for reduce_pkt_tx
//
// Purpose: groups the compute-side payload stream and the NetFPGA-style
// datapath stream of the reduce ring transmitter.
// Signals:
//   val_data/val_wr/val_rdy       partial-result words from compute logic
//   out_data/out_ctrl/out_wr/out_rdy  64-bit datapath toward the ring
// Modports:
//   master  the transmitter (consumes val_*, drives out_*)
//   slave   the surrounding logic (drives val_*, consumes out_*)
interface reduce_pkt_tx_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] val_data;
  logic                  val_wr;
  logic                  val_rdy;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CTRL_WIDTH-1:0] out_ctrl;
  logic                  out_wr;
  logic                  out_rdy;

  modport master (
    input  val_data, val_wr, out_rdy,
    output val_rdy, out_data, out_ctrl, out_wr
  );

  modport slave (
    output val_data, val_wr, out_rdy,
    input  val_rdy, out_data, out_ctrl, out_wr
  );
endinterface

// File: rtl/reduce_pkt_tx.sv
// rtl/reduce_pkt_tx.sv - reduce ring source: collects partial results, emits one framed packet
//
// Purpose: buffers NUM_WORDS 64-bit partial results, then sends them as one
// packet: module header (ctrl FF), MPI header, payload (last word ctrl 01),
// followed by one idle gap cycle.
// Ports:
//   clk       system clock
//   reset     asynchronous active-low reset
//   bus       reduce_pkt_tx_if.master (val_* in, out_* out)
//   dst_port  one-hot output port, latched on header entry
//   rank, op  node rank and reduce opcode, latched on header entry
//   busy      high whenever not collecting payload
//   seq       sequence number of the next packet
module reduce_pkt_tx #(
  parameter int          DATA_WIDTH = 64,
  parameter int          CTRL_WIDTH = 8,
  parameter int          NUM_WORDS  = 4,
  parameter logic [15:0] MAGIC      = 16'hA5A5
) (
  input  logic                 clk,
  input  logic                 reset,
  reduce_pkt_tx_if.master      bus,
  input  logic [15:0]          dst_port,
  input  logic [7:0]           rank,
  input  logic [7:0]           op,
  output logic                 busy,
  output logic [15:0]          seq
);

  typedef enum logic [2:0] {COLLECT, HDR, MPI, PAY, GAP} state_t;

  localparam logic [3:0]            LAST      = 4'(NUM_WORDS - 1);
  localparam logic [15:0]           LEN_WORDS = 16'(NUM_WORDS + 1);
  localparam logic [15:0]           LEN_BYTES = 16'((NUM_WORDS + 1) * 8);
  localparam logic [15:0]           PAY_WORDS = 16'(NUM_WORDS);
  localparam logic [CTRL_WIDTH-1:0] CTRL_HDR  = CTRL_WIDTH'(8'hFF);
  localparam logic [CTRL_WIDTH-1:0] CTRL_MID  = CTRL_WIDTH'(8'h00);
  localparam logic [CTRL_WIDTH-1:0] CTRL_EOP  = CTRL_WIDTH'(8'h01);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [15:0]           seq_q, seq_d;
  logic [7:0]            rank_q, op_q;
  logic                  hdr_latch;
  logic                  buf_we;
  logic                  word_vld_q, word_vld_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] buffer [16];

  // The output register always holds the word that is offered in the current
  // cycle; it is loaded one step ahead, so the header is already on the bus in
  // the first HDR cycle. Gating the strobe with out_rdy keeps out_wr from ever
  // rising while downstream is stalled, without losing the registered data.
  assign bus.out_wr   = word_vld_q & bus.out_rdy;
  assign bus.out_data = data_q;
  assign bus.out_ctrl = ctrl_q;
  assign bus.val_rdy  = (state_q == COLLECT);
  assign busy         = (state_q != COLLECT);
  assign seq          = seq_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    seq_d      = seq_q;
    word_vld_d = word_vld_q;
    data_d     = data_q;
    ctrl_d     = ctrl_q;
    hdr_latch  = 1'b0;
    buf_we     = 1'b0;

    case (state_q)
      COLLECT: begin
        if (bus.val_wr) begin
          buf_we = 1'b1;
          if (cnt_q == LAST) begin
            // Header is built from the live sideband at the same edge that
            // latches rank/op, so the whole packet sees one consistent set.
            state_d    = HDR;
            cnt_d      = 4'd0;
            hdr_latch  = 1'b1;
            word_vld_d = 1'b1;
            data_d     = {dst_port, LEN_WORDS, 16'h0000, LEN_BYTES};
            ctrl_d     = CTRL_HDR;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      HDR: begin
        if (bus.out_rdy) begin
          state_d = MPI;
          data_d  = {MAGIC, seq_q, rank_q, op_q, PAY_WORDS};
          ctrl_d  = CTRL_MID;
        end
      end

      MPI: begin
        if (bus.out_rdy) begin
          state_d = PAY;
          cnt_d   = 4'd0;
          data_d  = buffer[0];
          ctrl_d  = (LAST == 4'd0) ? CTRL_EOP : CTRL_MID;
        end
      end

      PAY: begin
        if (bus.out_rdy) begin
          if (cnt_q == LAST) begin
            state_d    = GAP;
            cnt_d      = 4'd0;
            word_vld_d = 1'b0;
            data_d     = '0;
            ctrl_d     = '0;
          end else begin
            cnt_d  = cnt_q + 4'd1;
            data_d = buffer[cnt_q + 4'd1];
            ctrl_d = ((cnt_q + 4'd1) == LAST) ? CTRL_EOP : CTRL_MID;
          end
        end
      end

      GAP: begin
        state_d = COLLECT;
        cnt_d   = 4'd0;
        seq_d   = seq_q + 16'd1;
      end

      default: begin
        state_d    = COLLECT;
        cnt_d      = 4'd0;
        word_vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= COLLECT;
      cnt_q      <= 4'd0;
      seq_q      <= 16'd0;
      rank_q     <= 8'd0;
      op_q       <= 8'd0;
      word_vld_q <= 1'b0;
      data_q     <= '0;
      ctrl_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      seq_q      <= seq_d;
      word_vld_q <= word_vld_d;
      data_q     <= data_d;
      ctrl_q     <= ctrl_d;
      if (hdr_latch) begin
        rank_q <= rank;
        op_q   <= op;
      end
    end
  end

  // Payload storage needs no reset: a reset returns cnt to 0, so stale
  // entries are always overwritten before they can be sent.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buffer[cnt_q] <= bus.val_data;
    end
  end

endmodule

// File: tb/tb_reduce_pkt_tx.sv
// tb/tb_reduce_pkt_tx.sv - self-checking bench for reduce_pkt_tx (NUM_WORDS=4 and NUM_WORDS=1)
module tb_reduce_pkt_tx;

  logic        clk;
  logic        reset;
  logic [15:0] dst4, dst1;
  logic [7:0]  rank4, op4, rank1, op1;
  logic        busy4, busy1;
  logic [15:0] seq4, seq1;

  reduce_pkt_tx_if bus4 ();
  reduce_pkt_tx_if bus1 ();

  reduce_pkt_tx #(.NUM_WORDS(4)) u_dut4 (
    .clk(clk), .reset(reset), .bus(bus4),
    .dst_port(dst4), .rank(rank4), .op(op4),
    .busy(busy4), .seq(seq4)
  );

  reduce_pkt_tx #(.NUM_WORDS(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1),
    .dst_port(dst1), .rank(rank1), .op(op1),
    .busy(busy1), .seq(seq1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int rdy_mode = 0;
  logic [71:0] cap4[$];
  logic [71:0] cap1[$];

  typedef struct {
    logic [15:0]  dst;
    logic [7:0]   rank;
    logic [7:0]   op;
    logic [255:0] pay;
    int           bp;
    logic [63:0]  hdr;
    logic [63:0]  mpi;
    logic [15:0]  seq_after;
  } row_t;

  row_t rows[3];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out", name);
  endtask

  // Capture every transferred word; a word may only move with out_rdy high.
  initial begin
    forever begin
      @(negedge clk);
      if (bus4.out_wr === 1'b1) begin
        cap4.push_back({bus4.out_ctrl, bus4.out_data});
        chk("out_wr_without_rdy4", {71'd0, bus4.out_rdy}, 72'd1);
      end
      if (bus1.out_wr === 1'b1) begin
        cap1.push_back({bus1.out_ctrl, bus1.out_data});
        chk("out_wr_without_rdy1", {71'd0, bus1.out_rdy}, 72'd1);
      end
    end
  end

  // out_rdy pattern for the 4-word instance: always, 1-0-0 repeating, random.
  initial begin
    int phase;
    phase = 0;
    bus4.out_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      phase++;
      case (rdy_mode)
        0:       bus4.out_rdy = 1'b1;
        1:       bus4.out_rdy = ((phase % 3) == 0);
        default: bus4.out_rdy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic write4(input logic [255:0] ws, input int n);
    for (int i = 0; i < n; i++) begin
      logic ok;
      int   t;
      bus4.val_data = ws[64*i +: 64];
      bus4.val_wr   = 1'b1;
      ok = 1'b0;
      t  = 0;
      while (!ok && t < 100) begin
        @(negedge clk);
        ok = bus4.val_rdy;
        @(posedge clk);
        #1;
        t++;
      end
      if (!ok) timeout_fail("val_rdy_wait");
    end
    bus4.val_wr = 1'b0;
  endtask

  task automatic wait_cap4(input int n);
    int t;
    t = 0;
    while (cap4.size() < n && t < 300) begin
      @(posedge clk);
      #2;
      t++;
    end
    if (cap4.size() < n) timeout_fail("output_words_wait");
  endtask

  task automatic check_pkt4(input string name, input logic [63:0] hdr, input logic [63:0] mpi,
                            input logic [255:0] pay, input logic [15:0] seq_exp);
    int t;
    wait_cap4(6);
    for (int i = 0; i < 6; i++) begin
      logic [71:0] exp;
      logic [71:0] act;
      if (i == 0)      exp = {8'hFF, hdr};
      else if (i == 1) exp = {8'h00, mpi};
      else             exp = {(i == 5) ? 8'h01 : 8'h00, pay[64*(i-2) +: 64]};
      act = (cap4.size() > 0) ? cap4.pop_front() : 72'hx;
      chk($sformatf("%s_word%0d", name, i), act, exp);
    end
    t = 0;
    while (busy4 && t < 50) begin
      @(posedge clk);
      #2;
      t++;
    end
    if (busy4) timeout_fail({name, "_busy_drop"});
    chk({name, "_seq"}, {56'd0, seq4}, {56'd0, seq_exp});
    @(posedge clk);
    #2;
    chk({name, "_no_extra_words"}, 72'(cap4.size()), 72'd0);
  endtask

  initial begin
    int acc;
    int viol;
    int busy_cyc;
    int t;

    rows[0] = '{dst: 16'h0004, rank: 8'h03, op: 8'h01,
                pay: {64'd4, 64'd3, 64'd2, 64'd1}, bp: 0,
                hdr: 64'h0004_0005_0000_0028, mpi: 64'hA5A5_0000_0301_0004, seq_after: 16'd1};
    rows[1] = '{dst: 16'h0001, rank: 8'h07, op: 8'h02,
                pay: {64'hDEAD_BEEF_0000_0004, 64'hDEAD_BEEF_0000_0003,
                      64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0001}, bp: 1,
                hdr: 64'h0001_0005_0000_0028, mpi: 64'hA5A5_0001_0702_0004, seq_after: 16'd2};
    rows[2] = '{dst: 16'h8000, rank: 8'hFF, op: 8'h80,
                pay: {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555,
                      64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF}, bp: 2,
                hdr: 64'h8000_0005_0000_0028, mpi: 64'hA5A5_0002_FF80_0004, seq_after: 16'd3};

    reset = 1'b0;
    bus4.val_wr = 1'b0; bus4.val_data = '0;
    bus1.val_wr = 1'b0; bus1.val_data = '0; bus1.out_rdy = 1'b1;
    dst4 = '0; rank4 = '0; op4 = '0;
    dst1 = '0; rank1 = '0; op1 = '0;
    repeat (3) @(posedge clk);
    #1;

    chk("rst_out_wr",   {71'd0, bus4.out_wr},  72'd0);
    chk("rst_out_data", {8'd0, bus4.out_data}, 72'd0);
    chk("rst_out_ctrl", {64'd0, bus4.out_ctrl}, 72'd0);
    chk("rst_seq",      {56'd0, seq4},          72'd0);
    chk("rst_val_rdy",  {71'd0, bus4.val_rdy},  72'd1);
    chk("rst_busy",     {71'd0, busy4},         72'd0);

    reset = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven packets; sideband is scrambled once the header is latched.
    for (int r = 0; r < 3; r++) begin
      dst4 = rows[r].dst; rank4 = rows[r].rank; op4 = rows[r].op;
      rdy_mode = rows[r].bp;
      write4(rows[r].pay, 4);
      dst4 = 16'hFFFF; rank4 = 8'hEE; op4 = 8'hDD;
      check_pkt4($sformatf("row%0d", r), rows[r].hdr, rows[r].mpi, rows[r].pay, rows[r].seq_after);
      rdy_mode = 0;
      @(posedge clk);
      #1;
    end

    // val_wr held high for 12 cycles: 4 words for this packet, then one more
    // once collection reopens after the gap.
    dst4 = 16'h0010; rank4 = 8'h05; op4 = 8'h06;
    acc = 0; viol = 0; busy_cyc = 0;
    for (int i = 0; i < 12; i++) begin
      bus4.val_data = 64'h10 + 64'(i);
      bus4.val_wr   = 1'b1;
      @(negedge clk);
      if (bus4.val_rdy) acc++;
      if (busy4) busy_cyc++;
      if (busy4 && bus4.val_rdy) viol++;
      @(posedge clk);
      #1;
    end
    bus4.val_wr = 1'b0;
    chk("block_accepted",   72'(acc),      72'd5);
    chk("block_busy_cycles", 72'(busy_cyc), 72'd7);
    chk("block_rdy_in_busy", 72'(viol),    72'd0);
    check_pkt4("blockA", 64'h0010_0005_0000_0028, 64'hA5A5_0003_0506_0004,
               {64'h13, 64'h12, 64'h11, 64'h10}, 16'd4);
    write4({64'h0, 64'h22, 64'h21, 64'h20}, 3);
    check_pkt4("blockB", 64'h0010_0005_0000_0028, 64'hA5A5_0004_0506_0004,
               {64'h22, 64'h21, 64'h20, 64'h1B}, 16'd5);

    // Reset in the middle of the payload.
    dst4 = 16'h0002; rank4 = 8'h09; op4 = 8'h0A;
    write4({64'h24, 64'h23, 64'h22, 64'h21}, 4);
    wait_cap4(3);
    reset = 1'b0;
    #1;
    chk("midrst_out_wr",  {71'd0, bus4.out_wr},  72'd0);
    chk("midrst_seq",     {56'd0, seq4},         72'd0);
    chk("midrst_busy",    {71'd0, busy4},        72'd0);
    chk("midrst_val_rdy", {71'd0, bus4.val_rdy}, 72'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cap4.delete();
    write4({64'h34, 64'h33, 64'h32, 64'h31}, 4);
    check_pkt4("after_rst", 64'h0002_0005_0000_0028, 64'hA5A5_0000_090A_0004,
               {64'h34, 64'h33, 64'h32, 64'h31}, 16'd1);

    // Sequence wrap.
    force u_dut4.seq_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release u_dut4.seq_q;
    dst4 = 16'h0040; rank4 = 8'h01; op4 = 8'h02;
    write4({64'h44, 64'h43, 64'h42, 64'h41}, 4);
    check_pkt4("wrapFFFF", 64'h0040_0005_0000_0028, 64'hA5A5_FFFF_0102_0004,
               {64'h44, 64'h43, 64'h42, 64'h41}, 16'd0);
    write4({64'h54, 64'h53, 64'h52, 64'h51}, 4);
    check_pkt4("wrap0000", 64'h0040_0005_0000_0028, 64'hA5A5_0000_0102_0004,
               {64'h54, 64'h53, 64'h52, 64'h51}, 16'd1);

    // NUM_WORDS=1 instance.
    dst1 = 16'h0002; rank1 = 8'h01; op1 = 8'h03;
    bus1.val_data = 64'h0123_4567_89AB_CDEF;
    bus1.val_wr   = 1'b1;
    @(posedge clk);
    #1;
    bus1.val_wr = 1'b0;
    dst1 = 16'hFFFF; rank1 = 8'hEE; op1 = 8'hDD;
    t = 0;
    while (cap1.size() < 3 && t < 50) begin
      @(posedge clk);
      #2;
      t++;
    end
    if (cap1.size() < 3) timeout_fail("nw1_words_wait");
    chk("nw1_hdr", (cap1.size() > 0) ? cap1.pop_front() : 72'hx, {8'hFF, 64'h0002_0002_0000_0010});
    chk("nw1_mpi", (cap1.size() > 0) ? cap1.pop_front() : 72'hx, {8'h00, 64'hA5A5_0000_0103_0001});
    chk("nw1_pay", (cap1.size() > 0) ? cap1.pop_front() : 72'hx, {8'h01, 64'h0123_4567_89AB_CDEF});
    repeat (3) @(posedge clk);
    #2;
    chk("nw1_seq",      {56'd0, seq1},  72'd1);
    chk("nw1_busy",     {71'd0, busy1}, 72'd0);
    chk("nw1_no_extra", 72'(cap1.size()), 72'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
